mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Bus initiator for the 64x16 single-port synchronous data memory: issues `mem_read`/`mem_write`/address/write-data and consumes registered `read_data`.
- Performs block COPY (src to dst) or FILL (constant to dst) of up to 64 words without CPU involvement.
- Sits beside the core's load/store path; a top-level mux grants the memory port to this engine while `busy`=1.

Parameters:
- ADDR_W, 6, memory word-address width (depth 2**ADDR_W).
- DATA_W, 16, memory word width.
- LEN_W, 7, transfer-length width; must equal ADDR_W+1 so a full-memory transfer is expressible.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0=COPY, 1=FILL; latched at start.
- src_addr  in  ADDR_W  COPY source base; latched at start.
- dst_addr  in  ADDR_W  destination base; latched at start.
- length  in  LEN_W  word count 0..64; latched at start.
- fill_value  in  DATA_W  FILL data; latched at start.
- abort  in  1  stop transfer at the next edge.
- mem_addr  out  ADDR_W  address to memory.
- mem_write_data  out  DATA_W  write data to memory.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_read_data  in  DATA_W  memory registered read output, valid the cycle after the `mem_read` cycle.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on normal completion.
- words_done  out  LEN_W  words written in the current or last transfer.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - Outputs in reset: `busy`, `done`, `mem_read`, `mem_write`, `mem_addr`, `mem_write_data`, `words_done` all 0.
  - Latched operands cleared to 0.
- State encoding: IDLE, RD, WR, FIN. Memory strobes and `busy` are Moore outputs decoded from state; `done`=1 only in FIN.
- IDLE: strobes 0, `busy`=0.
  - On `start`=1: latch all operands, clear `words_done` and index i to 0.
  - Next state: FIN if length==0; else RD if mode=COPY; else WR.
- RD (COPY only): `mem_read`=1, `mem_addr`=src+i (mod 2**ADDR_W). Next state WR.
- WR: `mem_write`=1, `mem_addr`=dst+i (mod 2**ADDR_W).
  - `mem_write_data`: in COPY, `mem_read_data` (the memory holds it because `mem_read`=0 in WR); in FILL, latched `fill_value`.
  - On the edge: i++, `words_done`++.
  - If i+1==length, next state FIN; else RD (COPY) or WR (FIN-L).
- FIN: `done`=1, `busy`=0, strobes 0. Next state IDLE unconditionally; `start` in FIN is ignored.
- Throughput and latency:
  - COPY: 2 cycles/word; first read strobe is the cycle after the start edge; `done` at cycle 2*length+1 after start.
  - FILL: 1 cycle/word; `done` at cycle length+1 after start.
- `busy`=1 in RD and WR only.
- Address arithmetic: ADDR_W-bit wrap; dst=62, length=4 writes 62, 63, 0, 1.
- Overlap: strictly ascending forward copy, no hazard handling. With src<dst<src+length, already-copied words are re-read (pattern propagation) and this is defined behaviour.
- `start` while busy: ignored, operands unchanged.
- `abort` (RD or WR state): next state IDLE with no `done` pulse.
  - A write strobed in the abort cycle still commits.
  - `words_done` reflects the count including that write.
  - `abort` in IDLE or FIN has no effect.
- `abort` and `start` together in IDLE: start wins; `abort` is only honoured in RD/WR.
- length>64: upper bits beyond 64 are not checked; caller responsibility. The bench constrains length<=64.
- `mem_read` and `mem_write` are never both 1.
- `mem_addr` and `mem_write_data` are 0 whenever both strobes are 0.

Decomposition:
- Shared package `mem_pkg`: ADDR_W, DATA_W, LEN_W constants, and the `xfer_mode_e` enum (COPY, FILL).
- Engine-local state enum `copy_state_e` (IDLE, RD, WR, FIN).
- No sub-module: single FSM plus datapath registers.
- Testbench instantiates `mem_copy_engine` together with the existing data memory.

Test Plan:
- COPY, mem[0..3]=0xA001..0xA004, src=0, dst=10, length=4 -> mem[10..13]=0xA001..0xA004; `done` 9 cycles after start; `words_done`=4; strobes never overlap.
- FILL, fill_value=0xBEEF, dst=62, length=4 -> mem[62], mem[63], mem[0], mem[1]=0xBEEF; mem[2] unchanged; `done` 5 cycles after start.
- length=0 -> no strobes ever asserted; `done` pulses the cycle after start; `words_done`=0.
- Start pulsed mid-transfer with different operands -> ignored; original transfer completes unchanged.
- abort asserted in the 2nd WR of COPY length=8 -> exactly 2 destination words written; `busy` drops next cycle; no `done`; `words_done`=2.
- rst_n low mid-FILL (asynchronously, between edges) -> all outputs 0 immediately; state=IDLE; after release, a new start runs normally. Also cover a full 64-word COPY with length=64.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg: widths and transfer-mode encoding shared by the data-memory slice.
// Revision: 1.0
// ============================================================================
package mem_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int LEN_W  = ADDR_W + 1;

  typedef enum logic {
    COPY = 1'b0,
    FILL = 1'b1
  } xfer_mode_e;

endpackage
`default_nettype wire

// File: rtl/mem_copy_engine_if.sv
`default_nettype none
// ============================================================================
// mem_copy_engine_if: single-port data-memory bus between initiator and memory.
// Revision: 1.0
// ============================================================================
interface mem_copy_engine_if;
  import mem_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output mem_addr,
    output mem_write_data,
    output mem_read,
    output mem_write,
    input  mem_read_data
  );

  modport slave (
    input  mem_addr,
    input  mem_write_data,
    input  mem_read,
    input  mem_write,
    output mem_read_data
  );

endinterface
`default_nettype wire

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
// mem_copy_engine: block COPY (src->dst) / FILL (constant->dst) bus initiator.
// Revision: 1.0
// ============================================================================
module mem_copy_engine
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  xfer_mode_e        mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  mem_copy_engine_if.master mem,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } copy_state_e;

  copy_state_e       r_state;
  copy_state_e       w_state_nxt;
  xfer_mode_e        r_mode;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [LEN_W-1:0]  r_words;
  logic [DATA_W-1:0] r_fill;
  logic              w_last;
  logic              w_accept;

  assign w_last   = (r_idx + LEN_W'(1)) == r_len;
  assign w_accept = (r_state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (length == '0)       w_state_nxt = FIN;
          else if (mode == COPY)  w_state_nxt = RD;
          else                    w_state_nxt = WR;
        end
      end
      RD: begin
        w_state_nxt = abort ? IDLE : WR;
      end
      WR: begin
        if (abort)               w_state_nxt = IDLE;
        else if (w_last)         w_state_nxt = FIN;
        else if (r_mode == COPY) w_state_nxt = RD;
        else                     w_state_nxt = WR;
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The WR-edge count also runs on an aborted write, since that write still commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= COPY;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_fill  <= '0;
      r_idx   <= '0;
      r_words <= '0;
    end else if (w_accept) begin
      r_mode  <= mode;
      r_src   <= src_addr;
      r_dst   <= dst_addr;
      r_len   <= length;
      r_fill  <= fill_value;
      r_idx   <= '0;
      r_words <= '0;
    end else if (r_state == WR) begin
      r_idx   <= r_idx + LEN_W'(1);
      r_words <= r_words + LEN_W'(1);
    end
  end

  always_comb begin
    mem.mem_read       = 1'b0;
    mem.mem_write      = 1'b0;
    mem.mem_addr       = '0;
    mem.mem_write_data = '0;
    busy               = 1'b0;
    done               = 1'b0;
    case (r_state)
      RD: begin
        mem.mem_read = 1'b1;
        mem.mem_addr = r_src + ADDR_W'(r_idx);
        busy         = 1'b1;
      end
      WR: begin
        mem.mem_write      = 1'b1;
        mem.mem_addr       = r_dst + ADDR_W'(r_idx);
        mem.mem_write_data = (r_mode == FILL) ? r_fill : mem.mem_read_data;
        busy               = 1'b1;
      end
      FIN: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign words_done = r_words;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
// tb_mem_copy_engine: engine plus 64x16 data memory, write scoreboard checks.
// Revision: 1.0
// ============================================================================
module tb_mem_copy_engine;
  import mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  xfer_mode_e        mode = COPY;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic [DATA_W-1:0] fill_value = '0;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  words_done;

  int n_checks = 0;
  int n_fail = 0;
  int strobe_cnt = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  logic [DATA_W-1:0] mem [64];
  logic [DATA_W-1:0] ref_mem [64];
  logic [DATA_W-1:0] rd_q = '0;
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [DATA_W-1:0] bd_data = '0;

  mem_copy_engine_if bus ();

  mem_copy_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .abort      (abort),
    .mem        (bus),
    .busy       (busy),
    .done       (done),
    .words_done (words_done)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, registered read that holds between reads.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_write_data;
    if (bus.mem_read) rd_q <= mem[bus.mem_addr];
  end
  assign bus.mem_read_data = rd_q;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_read || bus.mem_write) strobe_cnt++;
      n_checks++;
      if ((bus.mem_read && bus.mem_write) !== 1'b0) begin
        n_fail++;
        $display("FAIL strobe_overlap read=%b write=%b required not both", bus.mem_read, bus.mem_write);
      end
      if (!bus.mem_read && !bus.mem_write) begin
        n_checks++;
        if (bus.mem_addr !== '0 || bus.mem_write_data !== '0) begin
          n_fail++;
          $display("FAIL idle_bus addr=%h wdata=%h required 0/0", bus.mem_addr, bus.mem_write_data);
        end
      end
      if (bus.mem_write) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write addr=%h data=%h required no write", bus.mem_addr, bus.mem_write_data);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.mem_addr, bus.mem_write_data} !== mon_e) begin
            n_fail++;
            $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                     bus.mem_addr, bus.mem_write_data, mon_e.a, mon_e.d);
          end
        end
      end
    end
  end

  task automatic mem_poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Sequential reference copy: each word is read just before its write, so overlap propagates.
  task automatic push_expected(input xfer_mode_e m, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                               input logic [DATA_W-1:0] f, input int nwr);
    for (int k = 0; k < nwr; k++) begin
      logic [ADDR_W-1:0] wa;
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] wd;
      wa = d + ADDR_W'(k);
      ra = s + ADDR_W'(k);
      wd = (m == FILL) ? f : ref_mem[ra];
      ref_mem[wa] = wd;
      exp_q.push_back({wa, wd});
    end
  endtask

  task automatic run_xfer(input xfer_mode_e m, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] f,
                          input int abort_at, input int start_at,
                          output int done_cyc, output logic end_busy,
                          output logic [LEN_W-1:0] wd, output logic dbl_done);
    int cyc;
    mode = m; src_addr = s; dst_addr = d; length = l; fill_value = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    done_cyc = 0;
    while (cyc <= 200) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (abort_at != 0 && cyc == abort_at + 1) break;
      abort = (cyc == abort_at);
      if (cyc == start_at) begin
        start = 1'b1;
        mode = (m == COPY) ? FILL : COPY;
        src_addr = s + 6'd17; dst_addr = d + 6'd9; length = 7'd5; fill_value = 16'hDEAD;
      end
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      cyc++;
    end
    wd = words_done;
    end_busy = busy;
    @(posedge clk); #1;
    dbl_done = done;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy, done, bus.mem_read, bus.mem_write} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl busy/done/rd/wr=%b required 0000", {busy, done, bus.mem_read, bus.mem_write});
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_write_data, words_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_data addr=%h wdata=%h words=%0d required 0", bus.mem_addr, bus.mem_write_data, words_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release busy=%b required 0", busy);
    end
  endtask

  task automatic test_copy();
    int dc; logic eb; logic dd; logic [LEN_W-1:0] wd;
    for (int k = 0; k < 4; k++) mem_poke(ADDR_W'(k), 16'hA001 + 16'(k));
    push_expected(COPY, 6'd0, 6'd10, '0, 4);
    run_xfer(COPY, 6'd0, 6'd10, 7'd4, 16'h0, 0, 0, dc, eb, wd, dd);
    n_checks++;
    if (dc !== 9) begin n_fail++; $display("FAIL copy_done_cycle got=%0d required 9", dc); end
    n_checks++;
    if (wd !== 7'd4) begin n_fail++; $display("FAIL copy_words got=%0d required 4", wd); end
    n_checks++;
    if (dd !== 1'b0) begin n_fail++; $display("FAIL copy_done_pulse second_cycle=%b required 0", dd); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mem[10 + k] !== 16'hA001 + 16'(k)) begin
        n_fail++;
        $display("FAIL copy_mem[%0d] got=%h required %h", 10 + k, mem[10 + k], 16'hA001 + 16'(k));
      end
    end
  endtask

  task automatic test_fill_wrap();
    int dc; logic eb; logic dd; logic [LEN_W-1:0] wd;
    mem_poke(6'd2, 16'h1111);
    push_expected(FILL, 6'd0, 6'd62, 16'hBEEF, 4);
    run_xfer(FILL, 6'd0, 6'd62, 7'd4, 16'hBEEF, 0, 0, dc, eb, wd, dd);
    n_checks++;
    if (dc !== 5) begin n_fail++; $display("FAIL fill_done_cycle got=%0d required 5", dc); end
    n_checks++;
    if ({mem[62], mem[63], mem[0], mem[1]} !== {4{16'hBEEF}}) begin
      n_fail++;
      $display("FAIL fill_wrap got=%h %h %h %h required BEEF x4", mem[62], mem[63], mem[0], mem[1]);
    end
    n_checks++;
    if (mem[2] !== 16'h1111) begin n_fail++; $display("FAIL fill_past_end mem[2]=%h required 1111", mem[2]); end
  endtask

  task automatic test_zero_len();
    int dc; logic eb; logic dd; logic [LEN_W-1:0] wd; int s0;
    s0 = strobe_cnt;
    run_xfer(COPY, 6'd3, 6'd5, 7'd0, 16'h0, 0, 0, dc, eb, wd, dd);
    n_checks++;
    if (dc !== 1) begin n_fail++; $display("FAIL zero_done_cycle got=%0d required 1", dc); end
    n_checks++;
    if (wd !== 7'd0) begin n_fail++; $display("FAIL zero_words got=%0d required 0", wd); end
    n_checks++;
    if (strobe_cnt !== s0) begin n_fail++; $display("FAIL zero_strobes got=%0d required 0", strobe_cnt - s0); end
  endtask

  task automatic test_start_ignored();
    int dc; logic eb; logic dd; logic [LEN_W-1:0] wd;
    push_expected(COPY, 6'd0, 6'd30, '0, 4);
    run_xfer(COPY, 6'd0, 6'd30, 7'd4, 16'h0, 0, 3, dc, eb, wd, dd);
    n_checks++;
    if (dc !== 9) begin n_fail++; $display("FAIL busy_start_done_cycle got=%0d required 9", dc); end
    n_checks++;
    if (wd !== 7'd4) begin n_fail++; $display("FAIL busy_start_words got=%0d required 4", wd); end
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (mem[i] !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL busy_start_mem[%0d] got=%h required %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_abort();
    int dc; logic eb; logic dd; logic [LEN_W-1:0] wd;
    push_expected(COPY, 6'd0, 6'd40, '0, 2);
    run_xfer(COPY, 6'd0, 6'd40, 7'd8, 16'h0, 4, 0, dc, eb, wd, dd);
    n_checks++;
    if (dc !== 0 || dd !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%0d/%b required none", dc, dd); end
    n_checks++;
    if (eb !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b required 0", eb); end
    n_checks++;
    if (wd !== 7'd2) begin n_fail++; $display("FAIL abort_words got=%0d required 2", wd); end
    for (int i = 40; i < 48; i++) begin
      n_checks++;
      if (mem[i] !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL abort_mem[%0d] got=%h required %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int dc; logic eb; logic dd; logic [LEN_W-1:0] wd;
    push_expected(FILL, 6'd0, 6'd20, 16'h5A5A, 3);
    mode = FILL; dst_addr = 6'd20; length = 7'd10; fill_value = 16'h5A5A;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, bus.mem_read, bus.mem_write} !== 4'b0 || {bus.mem_addr, bus.mem_write_data, words_done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset ctrl=%b addr=%h wdata=%h words=%0d required all 0",
               {busy, done, bus.mem_read, bus.mem_write}, bus.mem_addr, bus.mem_write_data, words_done);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL async_reset_pending got=%0d required 0", exp_q.size()); end
    for (int i = 20; i < 24; i++) begin
      n_checks++;
      if (mem[i] !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL async_reset_mem[%0d] got=%h required %h", i, mem[i], ref_mem[i]);
      end
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    push_expected(FILL, 6'd0, 6'd50, 16'h7777, 3);
    run_xfer(FILL, 6'd0, 6'd50, 7'd3, 16'h7777, 0, 0, dc, eb, wd, dd);
    n_checks++;
    if (dc !== 4 || wd !== 7'd3) begin
      n_fail++;
      $display("FAIL post_reset_fill done_cycle=%0d words=%0d required 4/3", dc, wd);
    end
  endtask

  task automatic test_full_copy();
    int dc; logic eb; logic dd; logic [LEN_W-1:0] wd;
    for (int i = 0; i < 64; i++) mem_poke(ADDR_W'(i), 16'($urandom));
    push_expected(COPY, 6'd0, 6'd32, '0, 64);
    run_xfer(COPY, 6'd0, 6'd32, 7'd64, 16'h0, 0, 0, dc, eb, wd, dd);
    n_checks++;
    if (dc !== 129) begin n_fail++; $display("FAIL full_done_cycle got=%0d required 129", dc); end
    n_checks++;
    if (wd !== 7'd64) begin n_fail++; $display("FAIL full_words got=%0d required 64", wd); end
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (mem[i] !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL full_mem[%0d] got=%h required %h", i, mem[i], ref_mem[i]);
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL pending_writes got=%0d required 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_copy();
    test_fill_wrap();
    test_zero_len();
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_full_copy();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
